// File: rtl/mem_arbiter.sv
// Round-robin 2:1 arbiter merging I-cache and D-cache line requests onto one memory port.
// Each transaction walks IDLE -> BUSY -> RESP -> GAP; all outputs are registered.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        arb_grant
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic [1:0]          grant_q, grant_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;

    logic i_req, d_req, pick_d;

    assign i_req  = i_read | i_write;
    assign d_req  = d_read | d_write;
    // On a tie the port that was not served last wins; last_d_q resets to 0 so D wins first.
    assign pick_d = d_req & (~i_req | ~last_d_q);

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        grant_d     = grant_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                if (i_req | d_req) begin
                    state_d = BUSY;
                    if (pick_d) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_write_d = d_write;
                        mem_read_d  = d_read & ~d_write;
                        grant_d     = GNT_D;
                        last_d_d    = 1'b1;
                    end else begin
                        mem_addr_d  = i_addr;
                        mem_wdata_d = i_wdata;
                        mem_write_d = i_write;
                        mem_read_d  = i_read & ~i_write;
                        grant_d     = GNT_I;
                        last_d_d    = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    // Writes capture mem_rdata too, so the cache sees a uniform handshake.
                    if (grant_q == GNT_D) d_rdata_d = mem_rdata;
                    else                  i_rdata_d = mem_rdata;
                    i_ready_d   = (grant_q == GNT_I);
                    d_ready_d   = (grant_q == GNT_D);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                grant_d = GNT_NONE;
                state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            grant_q     <= GNT_NONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            grant_q     <= grant_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign arb_grant = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected ready responses into a queue,
// an independent monitor pops and compares them on every ready pulse.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;
    logic [1:0]    arb_grant;

    rsp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [DW-1:0] A5   = {16{8'hA5}};
    localparam logic [DW-1:0] D1   = {4{32'h0D0D_0001}};
    localparam logic [DW-1:0] I2   = {4{32'h1111_2222}};
    localparam logic [DW-1:0] DEAD = {4{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] W3   = {4{32'h3333_0003}};
    localparam logic [DW-1:0] S1   = {4{32'h5151_5151}};
    localparam logic [DW-1:0] JUNK = {4{32'hBAD0_BAD0}};

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .arb_grant(arb_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] port, input logic [DW-1:0] data);
        rsp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drive one mem_ready beat; returns in the RESP cycle.
    task automatic mem_done(input logic [DW-1:0] d);
        mem_rdata = d;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int c;
        c = 0;
        while (!(mem_read | mem_write) && c < 50) begin
            step();
            c++;
        end
        if (c >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no memory request, expected one within 50 cycles", nm);
        end
    endtask

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ready: got i=%0b d=%0b expected none", i_ready, d_ready);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_port", {d_ready, i_ready}, e.port);
                    chk("rsp_data", d_ready ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        step(3);
        chk("reset_ctrl", {mem_read, mem_write, arb_grant, i_ready, d_ready}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_rdata", {i_rdata | d_rdata}, 0);
        rst_n = 1'b1;
        step();

        // Single I read
        i_read = 1; i_addr = 28'h0000010;
        step();
        chk("t1_mem_read", mem_read, 1);
        chk("t1_mem_write", mem_write, 0);
        chk("t1_addr", mem_addr, 28'h0000010);
        chk("t1_grant", arb_grant, 2'b01);
        push(2'b01, A5);
        step(3);
        mem_done(A5);
        chk("t1_i_ready", i_ready, 1);
        chk("t1_d_ready", d_ready, 0);
        chk("t1_i_rdata", i_rdata, A5);
        chk("t1_mem_read_clr", mem_read, 0);
        i_read = 0;
        step();
        chk("t1_gap_grant", arb_grant, 2'b00);
        chk("t1_gap_ready", i_ready, 0);
        step();

        // Tie after reset: D first, I at m+4
        d_read = 1; d_addr = 28'h0ABCDEF; i_read = 1; i_addr = 28'h0000020;
        step();
        chk("t2_grant_d", arb_grant, 2'b10);
        chk("t2_addr_d", mem_addr, 28'h0ABCDEF);
        push(2'b10, D1);
        step();
        mem_done(D1);
        d_read = 0;
        step();
        chk("t2_m2_read", mem_read, 0);
        step();
        chk("t2_m3_read", mem_read, 0);
        step();
        chk("t2_m4_read", mem_read, 1);
        chk("t2_grant_i", arb_grant, 2'b01);
        chk("t2_addr_i", mem_addr, 28'h0000020);
        push(2'b01, I2);
        step();
        mem_done(I2);
        i_read = 0;
        step(2);

        // D write-back, inputs change during BUSY
        d_write = 1; d_addr = 28'h1234567; d_wdata = DEAD;
        step();
        chk("t3_mem_write", mem_write, 1);
        chk("t3_mem_read", mem_read, 0);
        chk("t3_addr", mem_addr, 28'h1234567);
        chk("t3_wdata", mem_wdata, DEAD);
        chk("t3_grant", arb_grant, 2'b10);
        i_wdata = '1; d_wdata = '0; d_addr = '0;
        push(2'b10, W3);
        step(2);
        chk("t3_hold_write", mem_write, 1);
        chk("t3_hold_addr", mem_addr, 28'h1234567);
        chk("t3_hold_wdata", mem_wdata, DEAD);
        mem_done(W3);
        chk("t3_d_ready", d_ready, 1);
        chk("t3_write_clr", mem_write, 0);
        d_write = 0;
        step(2);

        // Spurious mem_ready in IDLE, then in RESP and GAP
        mem_rdata = JUNK; mem_ready = 1;
        step(2);
        chk("sp_idle_ready", {i_ready, d_ready}, 0);
        chk("sp_idle_state", {mem_read, mem_write, arb_grant}, 0);
        chk("sp_idle_i_rdata", i_rdata, I2);
        chk("sp_idle_d_rdata", d_rdata, W3);
        mem_ready = 0;
        i_read = 1; i_addr = 28'h0000030;
        step();
        push(2'b01, S1);
        mem_rdata = S1; mem_ready = 1;
        step();
        chk("sp_resp_ready", i_ready, 1);
        mem_rdata = JUNK;
        i_read = 0;
        step();
        chk("sp_gap_ready", i_ready, 0);
        chk("sp_gap_i_rdata", i_rdata, S1);
        chk("sp_gap_d_rdata", d_rdata, W3);
        step();
        chk("sp_idle2_ready", {i_ready, d_ready}, 0);
        chk("sp_idle2_state", {mem_read, mem_write, arb_grant}, 0);
        chk("sp_idle2_i_rdata", i_rdata, S1);
        mem_ready = 0;
        step();

        // Reset mid-transaction (D in BUSY, so last_grant must return to I)
        d_read = 1; d_addr = 28'h0555555;
        step();
        chk("rst_busy_read", mem_read, 1);
        chk("rst_busy_grant", arb_grant, 2'b10);
        rst_n = 0;
        #1;
        chk("rst_async_read", mem_read, 0);
        chk("rst_async_grant", arb_grant, 0);
        d_read = 0;
        step(2);
        rst_n = 1;
        step();
        mem_rdata = JUNK; mem_ready = 1;
        step();
        mem_ready = 0;
        chk("rst_late_ready", {i_ready, d_ready}, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_read", mem_read, 0);
        step(2);

        // Fairness: both held, grants alternate D, I, D, I
        i_read = 1; i_addr = 28'h0000040; d_read = 1; d_addr = 28'h0000050;
        for (int k = 0; k < 4; k++) begin
            logic [1:0]    eg;
            logic [DW-1:0] dk;
            wait_req("fair_req");
            eg = (k % 2 == 0) ? 2'b10 : 2'b01;
            dk = {4{32'hF00D_0000 + 32'(k)}};
            chk("fair_grant", arb_grant, eg);
            chk("fair_addr", mem_addr, (k % 2 == 0) ? 28'h0000050 : 28'h0000040);
            push(eg, dk);
            step();
            mem_done(dk);
            if (k == 3) begin
                i_read = 0;
                d_read = 0;
            end
            step(2);
        end

        step(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
